// File: rtl/pat_gradient_anim.sv
// Purpose: animated two-colour gradient generator for an addressable LED strip
//          (parity, static linear, scrolling and bouncing gradient modes).
// Latency: 2 cycles from next_led_request to its colour; color_valid marks a match.
// Backpressure: none; the driver holds a request until color_valid is high.
//
// Ports:
//   clk_in, rst_in        sole clock, synchronous active-high reset
//   frame_start           one-cycle pulse per strip refresh; latches configuration
//   mode_in, speed_in     animation mode and frames-per-step minus one
//   color_a_in/_b_in      gradient endpoints, packed {R,G,B}
//   next_led_request      LED index the driver wants next
//   red/green/blue_out    colour of the requested LED
//   color_valid           colour outputs belong to the current request
module pat_gradient_anim #(
  parameter int NUM_LEDS    = 20,
  parameter int COLOR_WIDTH = 8,
  localparam int CounterWidth = $clog2(NUM_LEDS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       frame_start,
  input  logic [1:0]                 mode_in,
  input  logic [7:0]                 speed_in,
  input  logic [3*COLOR_WIDTH-1:0]   color_a_in,
  input  logic [3*COLOR_WIDTH-1:0]   color_b_in,
  input  logic [CounterWidth-1:0]    next_led_request,
  output logic [COLOR_WIDTH-1:0]     red_out,
  output logic [COLOR_WIDTH-1:0]     green_out,
  output logic [COLOR_WIDTH-1:0]     blue_out,
  output logic                       color_valid
);

  typedef enum logic [1:0] {
    MODE_PARITY = 2'd0,
    MODE_LINEAR = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  localparam int CW = COLOR_WIDTH;
  // Blend accumulator: A*(2^CW-w) + B*w never exceeds (2^CW-1)*2^CW.
  localparam int BW = 2 * CW + 2;

  // Fixed-point (16 fractional bits) weight increment per LED position.
  localparam logic [63:0] Step =
    ((64'd1 << COLOR_WIDTH) - 64'd1) * 64'd65536 / 64'(NUM_LEDS - 1);

  localparam logic [CounterWidth-1:0] LastIdx    = CounterWidth'(NUM_LEDS - 1);
  localparam logic [CounterWidth:0]   NumLedsExt = (CounterWidth + 1)'(NUM_LEDS);
  localparam logic [CW:0]             Full       = (CW + 1)'(1) << CW;

  // Shadow configuration, only updated on frame_start.
  mode_t                  mode_q;
  logic [7:0]             speed_q;
  logic [3*CW-1:0]        col_a_q;
  logic [3*CW-1:0]        col_b_q;

  // Animation state.
  logic [7:0]              frame_cnt;
  logic [CounterWidth-1:0] offset;
  logic                    dir_down;
  logic [CounterWidth-1:0] offset_nxt;
  logic                    dir_nxt;

  // Pipeline state.
  logic [CounterWidth-1:0] p1;
  logic [CounterWidth-1:0] idx1;
  logic                    v1;
  logic [CounterWidth-1:0] idx2;
  logic                    v2;

  logic [CounterWidth:0]   pos_sum;
  logic [CounterWidth-1:0] pos;
  logic [CounterWidth-1:0] offset_eff;
  logic [CW:0]             wt;
  logic [3*CW-1:0]         pix;

  // ---------------------------------------------------------------------------
  // Offset step rule for the current (unchanged) mode.
  // ---------------------------------------------------------------------------
  always_comb begin
    offset_nxt = offset;
    dir_nxt    = dir_down;
    case (mode_q)
      MODE_SCROLL: begin
        offset_nxt = (offset == LastIdx) ? '0 : offset + CounterWidth'(1);
      end
      MODE_BOUNCE: begin
        if (!dir_down) begin
          if (offset == LastIdx) begin
            offset_nxt = LastIdx - CounterWidth'(1);
            dir_nxt    = 1'b1;
          end else begin
            offset_nxt = offset + CounterWidth'(1);
          end
        end else begin
          if (offset == '0) begin
            offset_nxt = CounterWidth'(1);
            dir_nxt    = 1'b0;
          end else begin
            offset_nxt = offset - CounterWidth'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Configuration latch, frame counter and offset animation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode_q    <= MODE_PARITY;
      speed_q   <= '0;
      col_a_q   <= '0;
      col_b_q   <= '0;
      frame_cnt <= '0;
      offset    <= '0;
      dir_down  <= 1'b0;
    end else if (frame_start) begin
      mode_q  <= mode_t'(mode_in);
      speed_q <= speed_in;
      col_a_q <= color_a_in;
      col_b_q <= color_b_in;
      if (mode_t'(mode_in) != mode_q) begin
        // A mode switch restarts the animation; no step on this frame.
        frame_cnt <= '0;
        offset    <= '0;
        dir_down  <= 1'b0;
      end else if (frame_cnt == speed_q) begin
        frame_cnt <= '0;
        offset    <= offset_nxt;
        dir_down  <= dir_nxt;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: strip position of the requested LED.
  // ---------------------------------------------------------------------------
  always_comb begin
    offset_eff = ((mode_q == MODE_SCROLL) || (mode_q == MODE_BOUNCE)) ? offset : '0;
    pos_sum    = {1'b0, next_led_request} + {1'b0, offset_eff};
    if (pos_sum >= NumLedsExt) begin
      pos_sum = pos_sum - NumLedsExt;
    end
    pos = pos_sum[CounterWidth-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p1   <= '0;
      idx1 <= '0;
      v1   <= 1'b0;
    end else begin
      p1   <= pos;
      idx1 <= next_led_request;
      v1   <= !frame_start;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour from position.
  // ---------------------------------------------------------------------------
  function automatic logic [CW-1:0] mix(input logic [CW-1:0] a,
                                        input logic [CW-1:0] b,
                                        input logic [CW:0]   w);
    logic [BW-1:0] acc;
    acc = BW'(a) * BW'(Full - w) + BW'(b) * BW'(w);
    return CW'(acc >> CW);
  endfunction

  always_comb begin
    wt  = (CW + 1)'((64'(p1) * Step) >> 16);
    pix = '0;
    if (mode_q == MODE_PARITY) begin
      pix = idx1[0] ? col_a_q : col_b_q;
    end else if (p1 == '0) begin
      // Endpoints bypass the blend so they match the configured colours exactly.
      pix = col_a_q;
    end else if (p1 == LastIdx) begin
      pix = col_b_q;
    end else begin
      pix = {mix(col_a_q[3*CW-1:2*CW], col_b_q[3*CW-1:2*CW], wt),
             mix(col_a_q[2*CW-1:CW],   col_b_q[2*CW-1:CW],   wt),
             mix(col_a_q[CW-1:0],      col_b_q[CW-1:0],      wt)};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      idx2      <= '0;
      v2        <= 1'b0;
    end else begin
      red_out   <= pix[3*CW-1:2*CW];
      green_out <= pix[2*CW-1:CW];
      blue_out  <= pix[CW-1:0];
      idx2      <= idx1;
      v2        <= frame_start ? 1'b0 : v1;
    end
  end

  // Both stages must hold the current request, so a request change masks
  // valid until the new index reaches the output registers.
  assign color_valid = v2 && (idx2 == next_led_request) && (idx1 == next_led_request);

endmodule

// File: tb/tb_pat_gradient_anim.sv
module tb_pat_gradient_anim;

  localparam logic [1:0] M_PARITY = 2'd0;
  localparam logic [1:0] M_LINEAR = 2'd1;
  localparam logic [1:0] M_SCROLL = 2'd2;
  localparam logic [1:0] M_BOUNCE = 2'd3;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        frame_start;
  logic [1:0]  mode_in;
  logic [7:0]  speed_in;
  logic [23:0] color_a_in;
  logic [23:0] color_b_in;
  logic [4:0]  next_led_request;
  logic [7:0]  red_out;
  logic [7:0]  green_out;
  logic [7:0]  blue_out;
  logic        color_valid;

  int checks = 0;
  int errors = 0;

  logic [23:0] col_a = 24'hFF0000;
  logic [23:0] col_b = 24'h0000FF;

  pat_gradient_anim #(.NUM_LEDS(20), .COLOR_WIDTH(8)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .frame_start      (frame_start),
    .mode_in          (mode_in),
    .speed_in         (speed_in),
    .color_a_in       (color_a_in),
    .color_b_in       (color_b_in),
    .next_led_request (next_led_request),
    .red_out          (red_out),
    .green_out        (green_out),
    .blue_out         (blue_out),
    .color_valid      (color_valid)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          frm;
    logic [1:0]  mode;
    logic [4:0]  req;
    logic        vld;
    bit          chk;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(bit frm, logic [1:0] mode, logic [4:0] req,
                              logic vld, bit chk, logic [23:0] rgb);
    vec_t v;
    v.frm = frm; v.mode = mode; v.req = req; v.vld = vld; v.chk = chk; v.rgb = rgb;
    return v;
  endfunction

  // Reference gradient for A=FF0000, B=0000FF, 20 LEDs, STEP=879562.
  function automatic logic [23:0] grad(input int p);
    int w;
    int ch[3];
    int ca;
    int cb;
    logic [23:0] a;
    logic [23:0] b;
    a = col_a;
    b = col_b;
    if (p == 0) return a;
    if (p == 19) return b;
    w = int'((longint'(p) * 64'd879562) >> 16);
    for (int c = 0; c < 3; c++) begin
      ca = int'(a[c*8 +: 8]);
      cb = int'(b[c*8 +: 8]);
      ch[c] = (ca * (256 - w) + cb * w) >> 8;
    end
    return {8'(ch[2]), 8'(ch[1]), 8'(ch[0])};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_rgb(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  // One frame pulse with A/B colours, then two settle cycles (request held).
  task automatic frame(input logic [1:0] m, input logic [7:0] spd);
    mode_in     = m;
    speed_in    = spd;
    color_a_in  = col_a;
    color_b_in  = col_b;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_offset(input string name, input int o);
    chk_bit({name, "_vld"}, color_valid, 1'b1);
    chk_rgb(name, {red_out, green_out, blue_out}, grad(o));
  endtask

  initial begin
    int expo;
    int pos;

    rst_in           = 1'b1;
    frame_start      = 1'b0;
    mode_in          = M_PARITY;
    speed_in         = 8'd0;
    color_a_in       = col_a;
    color_b_in       = col_b;
    next_led_request = 5'd0;

    vecs[0]  = mk(1, M_LINEAR, 5'd0,  1'b0, 0, 24'h0);
    vecs[1]  = mk(0, M_LINEAR, 5'd0,  1'b0, 0, 24'h0);
    vecs[2]  = mk(0, M_LINEAR, 5'd0,  1'b1, 1, 24'hFF0000);
    vecs[3]  = mk(0, M_LINEAR, 5'd0,  1'b1, 1, 24'hFF0000);
    vecs[4]  = mk(0, M_LINEAR, 5'd10, 1'b0, 0, 24'h0);
    vecs[5]  = mk(0, M_LINEAR, 5'd10, 1'b1, 1, 24'h790085);
    vecs[6]  = mk(0, M_LINEAR, 5'd10, 1'b1, 1, 24'h790085);
    vecs[7]  = mk(0, M_LINEAR, 5'd19, 1'b0, 0, 24'h0);
    vecs[8]  = mk(0, M_LINEAR, 5'd19, 1'b1, 1, 24'h0000FF);
    vecs[9]  = mk(0, M_LINEAR, 5'd19, 1'b1, 1, 24'h0000FF);
    vecs[10] = mk(0, M_LINEAR, 5'd1,  1'b0, 0, 24'h0);
    vecs[11] = mk(0, M_LINEAR, 5'd1,  1'b1, 1, 24'hF2000C);
    vecs[12] = mk(0, M_LINEAR, 5'd18, 1'b0, 0, 24'h0);
    vecs[13] = mk(0, M_LINEAR, 5'd18, 1'b1, 1, 24'h0E00F0);
    vecs[14] = mk(1, M_PARITY, 5'd5,  1'b0, 0, 24'h0);
    vecs[15] = mk(0, M_PARITY, 5'd5,  1'b0, 0, 24'h0);
    vecs[16] = mk(0, M_PARITY, 5'd5,  1'b1, 1, 24'hFF0000);
    vecs[17] = mk(0, M_PARITY, 5'd5,  1'b1, 1, 24'hFF0000);
    vecs[18] = mk(0, M_PARITY, 5'd4,  1'b0, 0, 24'h0);
    vecs[19] = mk(0, M_PARITY, 5'd4,  1'b1, 1, 24'h0000FF);
    vecs[20] = mk(0, M_PARITY, 5'd4,  1'b1, 1, 24'h0000FF);

    // Reset state.
    tick();
    tick();
    chk_bit("rst_vld", color_valid, 1'b0);
    chk_rgb("rst_rgb", {red_out, green_out, blue_out}, 24'h0);
    rst_in = 1'b0;
    tick();
    chk_bit("rel_vld_c1", color_valid, 1'b0);
    tick();
    chk_bit("rel_vld_c2", color_valid, 1'b1);
    chk_rgb("rel_rgb_zero", {red_out, green_out, blue_out}, 24'h0);

    // LINEAR and PARITY vectors.
    for (int i = 0; i < 21; i++) begin
      next_led_request = vecs[i].req;
      if (vecs[i].frm) begin
        mode_in     = vecs[i].mode;
        speed_in    = 8'd0;
        color_a_in  = col_a;
        color_b_in  = col_b;
        frame_start = 1'b1;
      end
      tick();
      frame_start = 1'b0;
      chk_bit($sformatf("vec%0d_vld", i), color_valid, vecs[i].vld);
      if (vecs[i].chk)
        chk_rgb($sformatf("vec%0d_rgb", i), {red_out, green_out, blue_out}, vecs[i].rgb);
    end

    // Configuration inputs are ignored without frame_start.
    mode_in    = M_LINEAR;
    color_a_in = 24'h00FF00;
    color_b_in = 24'h00FF00;
    tick();
    tick();
    chk_bit("ignore_vld", color_valid, 1'b1);
    chk_rgb("ignore_rgb", {red_out, green_out, blue_out}, 24'h0000FF);

    // SCROLL, speed 0: three steps after the mode-latch frame.
    next_led_request = 5'd0;
    frame(M_SCROLL, 8'd0);
    chk_offset("scroll0_off0", 0);
    for (int k = 1; k <= 3; k++) frame(M_SCROLL, 8'd0);
    chk_offset("scroll0_off3", 3);
    next_led_request = 5'd17;
    tick();
    tick();
    chk_bit("scroll0_req17_vld", color_valid, 1'b1);
    chk_rgb("scroll0_req17_rgb", {red_out, green_out, blue_out}, col_a);
    next_led_request = 5'd0;

    // SCROLL, speed 2: a step on every third frame, through the 19->0 wrap.
    frame(M_PARITY, 8'd2);
    frame(M_SCROLL, 8'd2);
    chk_offset("scroll2_off0", 0);
    for (int k = 1; k <= 60; k++) begin
      frame(M_SCROLL, 8'd2);
      chk_offset($sformatf("scroll2_f%0d", k), (k / 3) % 20);
    end

    // BOUNCE, speed 0: 0..19, 18..0, 1, 2.
    frame(M_PARITY, 8'd0);
    frame(M_BOUNCE, 8'd0);
    chk_offset("bounce_off0", 0);
    for (int k = 1; k <= 40; k++) begin
      frame(M_BOUNCE, 8'd0);
      pos  = k % 38;
      expo = (pos <= 19) ? pos : 38 - pos;
      chk_offset($sformatf("bounce_s%0d", k), expo);
    end

    // A frame pulse drops valid for exactly two cycles.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk_bit("pulse_c0", color_valid, 1'b0);
    tick();
    chk_bit("pulse_c1", color_valid, 1'b0);
    tick();
    chk_bit("pulse_c2", color_valid, 1'b1);
    chk_rgb("pulse_rgb", {red_out, green_out, blue_out}, grad(3));

    // Reset mid-SCROLL at offset 7, with a coinciding frame_start.
    frame(M_PARITY, 8'd0);
    frame(M_SCROLL, 8'd0);
    for (int k = 1; k <= 7; k++) frame(M_SCROLL, 8'd0);
    chk_offset("pre_rst_off7", 7);
    rst_in      = 1'b1;
    frame_start = 1'b1;
    mode_in     = M_LINEAR;
    color_a_in  = 24'h00FF00;
    color_b_in  = 24'h00FF00;
    tick();
    rst_in      = 1'b0;
    frame_start = 1'b0;
    chk_bit("mid_rst_vld", color_valid, 1'b0);
    chk_rgb("mid_rst_rgb", {red_out, green_out, blue_out}, 24'h0);
    tick();
    chk_bit("post_rst_c1_vld", color_valid, 1'b0);
    tick();
    chk_bit("post_rst_c2_vld", color_valid, 1'b1);
    chk_rgb("post_rst_rgb_zero", {red_out, green_out, blue_out}, 24'h0);
    frame(M_SCROLL, 8'd0);
    chk_offset("post_rst_off0", 0);
    frame(M_SCROLL, 8'd0);
    chk_offset("post_rst_off1", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
